// File: rtl/ps_setpoint_capture.sv
// Setpoint stream consumer: validates beat framing and commits each complete
// frame atomically into a double-buffered bank readable over the system bus.
//
// state   | meaning
// IDLE    | waiting for channel 0 of a new frame
// RECEIVE | collecting channels 1..RESULT_COUNT-1 into the write bank
// DISCARD | frame overran RESULT_COUNT beats, dropping beats until TLAST
module ps_setpoint_capture #(
    parameter int RESULT_COUNT       = 24,
    parameter int FLOAT_WIDTH        = 32,
    parameter int RESULT_COUNT_WIDTH = (RESULT_COUNT == 1) ? 1 : $clog2(RESULT_COUNT),
    parameter int FRAME_COUNT_WIDTH  = 16,
    parameter int ERROR_COUNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          SETPOINT_TVALID,
    input  logic                          SETPOINT_TLAST,
    input  logic [FLOAT_WIDTH-1:0]        SETPOINT_TDATA,
    input  logic [RESULT_COUNT_WIDTH-1:0] readAddress,
    output logic [FLOAT_WIDTH-1:0]        readData,
    output logic                          frameToggle,
    output logic [FRAME_COUNT_WIDTH-1:0]  frameCount,
    output logic [ERROR_COUNT_WIDTH-1:0]  shortFrameCount,
    output logic [ERROR_COUNT_WIDTH-1:0]  longFrameCount,
    input  logic                          clearErrors,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, RECEIVE, DISCARD} state_t;

    localparam int DEPTH = 2 ** RESULT_COUNT_WIDTH;
    localparam logic [RESULT_COUNT_WIDTH-1:0] LAST_IDX = RESULT_COUNT_WIDTH'(RESULT_COUNT - 1);

    state_t                        state;
    logic [RESULT_COUNT_WIDTH-1:0] idx;
    logic                          readBank;
    logic                          bankValid;
    logic [FLOAT_WIDTH-1:0]        bank0 [DEPTH];
    logic [FLOAT_WIDTH-1:0]        bank1 [DEPTH];

    logic                          wr_en;
    logic [RESULT_COUNT_WIDTH-1:0] wr_addr;
    logic                          commit;
    logic                          short_err;
    logic                          long_err;

    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = idx;
        commit    = 1'b0;
        short_err = 1'b0;
        long_err  = 1'b0;
        if (SETPOINT_TVALID) begin
            case (state)
                IDLE: begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    if (SETPOINT_TLAST) begin
                        if (RESULT_COUNT == 1) commit = 1'b1;
                        else                   short_err = 1'b1;
                    end
                end
                RECEIVE: begin
                    wr_en = 1'b1;
                    if (SETPOINT_TLAST) begin
                        if (idx == LAST_IDX) commit = 1'b1;
                        else                 short_err = 1'b1;
                    end
                end
                DISCARD: long_err = SETPOINT_TLAST;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            readBank    <= 1'b0;
            bankValid   <= 1'b0;
            frameToggle <= 1'b0;
            frameCount  <= '0;
        end else begin
            if (commit) begin
                readBank    <= ~readBank;
                bankValid   <= 1'b1;
                frameToggle <= ~frameToggle;
                frameCount  <= frameCount + FRAME_COUNT_WIDTH'(1);
            end
            if (SETPOINT_TVALID) begin
                case (state)
                    IDLE: begin
                        if (!SETPOINT_TLAST) begin
                            idx   <= RESULT_COUNT_WIDTH'(1);
                            state <= RECEIVE;
                            busy  <= 1'b1;
                        end
                    end
                    RECEIVE: begin
                        if (SETPOINT_TLAST) begin
                            idx   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (idx == LAST_IDX) begin
                            state <= DISCARD;
                        end else begin
                            idx <= idx + RESULT_COUNT_WIDTH'(1);
                        end
                    end
                    DISCARD: begin
                        if (SETPOINT_TLAST) begin
                            idx   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        idx   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A coincident clear beats the increment so software never misses a zero.
    always_ff @(posedge clk) begin
        if (reset || clearErrors) begin
            shortFrameCount <= '0;
            longFrameCount  <= '0;
        end else begin
            if (short_err && (shortFrameCount != '1))
                shortFrameCount <= shortFrameCount + ERROR_COUNT_WIDTH'(1);
            if (long_err && (longFrameCount != '1))
                longFrameCount <= longFrameCount + ERROR_COUNT_WIDTH'(1);
        end
    end

    // Only the non-committed bank is ever written.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            if (readBank) bank0[wr_addr] <= SETPOINT_TDATA;
            else          bank1[wr_addr] <= SETPOINT_TDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !bankValid || (readAddress > LAST_IDX))
            readData <= '0;
        else
            readData <= readBank ? bank1[readAddress] : bank0[readAddress];
    end

endmodule

// File: tb/tb_ps_setpoint_capture.sv
// Self-checking bench for ps_setpoint_capture: frame-level reference model with
// a readData scoreboard checked every clock.
module tb_ps_setpoint_capture;

    localparam int RC  = 24;
    localparam int FW  = 32;
    localparam int AW  = 5;
    localparam int FCW = 16;
    localparam int ECW = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           tvalid;
    logic           tlast;
    logic [FW-1:0]  tdata;
    logic [AW-1:0]  read_address;
    logic [FW-1:0]  read_data;
    logic           frame_toggle;
    logic [FCW-1:0] frame_count;
    logic [ECW-1:0] short_count;
    logic [ECW-1:0] long_count;
    logic           clear_errors;
    logic           busy;

    ps_setpoint_capture dut (
        .clk             (clk),
        .reset           (reset),
        .SETPOINT_TVALID (tvalid),
        .SETPOINT_TLAST  (tlast),
        .SETPOINT_TDATA  (tdata),
        .readAddress     (read_address),
        .readData        (read_data),
        .frameToggle     (frame_toggle),
        .frameCount      (frame_count),
        .shortFrameCount (short_count),
        .longFrameCount  (long_count),
        .clearErrors     (clear_errors),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [FW-1:0] model_bank [RC];
    bit            model_valid;
    bit            exp_toggle;
    int            exp_frames;
    int            exp_short;
    int            exp_long;
    logic [FW-1:0] rd_q [$];

    // IEEE single encoding of a small non-negative integer.
    function automatic logic [31:0] to_float(input int n);
        int          e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if (n >= (1 << i)) e = i;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    // Push the readData the model expects after this edge, clock, then score it.
    task automatic clock_and_score();
        logic [FW-1:0] exp_rd;
        logic [AW-1:0] addr;
        addr   = read_address;
        exp_rd = (model_valid && int'(addr) < RC) ? model_bank[addr] : '0;
        rd_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        exp_rd = rd_q.pop_front();
        vectors++;
        if (read_data !== exp_rd) begin
            miscompares++;
            $display("FAIL readData addr=%0d got %h expected %h at %0t", addr, read_data, exp_rd, $time);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        tvalid       = 1'b0;
        tlast        = 1'b0;
        tdata        = '0;
        clear_errors = 1'b0;
        model_valid  = 1'b0;
        exp_toggle   = 1'b0;
        exp_frames   = 0;
        exp_short    = 0;
        exp_long     = 0;
        repeat (2) clock_and_score();
        reset = 1'b0;
    endtask

    // Drive an n-beat frame (TLAST on the final beat), values base+k as floats.
    task automatic send_frame(input int n, input int base, input int max_gap, input bit clear_at_last);
        logic [FW-1:0] frame [RC];
        for (int k = 0; k < n; k++) begin
            if (k > 0 && max_gap > 0) begin
                repeat ($urandom_range(max_gap, 1)) begin
                    tvalid = 1'b0;
                    tlast  = 1'b1;
                    tdata  = 32'hDEAD_BEEF;
                    vectors++;
                    if (busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL busy_gap beat=%0d got %b expected 1", k, busy);
                    end
                    clock_and_score();
                end
            end
            tvalid       = 1'b1;
            tlast        = (k == n - 1);
            tdata        = to_float(base + k);
            clear_errors = clear_at_last && (k == n - 1);
            if (k < RC) frame[k] = tdata;
            vectors++;
            if (busy !== (k > 0)) begin
                miscompares++;
                $display("FAIL busy beat=%0d got %b expected %b", k, busy, (k > 0));
            end
            clock_and_score();
        end
        tvalid       = 1'b0;
        tlast        = 1'b0;
        clear_errors = 1'b0;
        if (n == RC) begin
            model_bank  = frame;
            model_valid = 1'b1;
            exp_toggle  = ~exp_toggle;
            exp_frames++;
        end else if (n < RC) begin
            if (exp_short < 255) exp_short++;
        end else begin
            if (exp_long < 255) exp_long++;
        end
        if (clear_at_last) begin
            exp_short = 0;
            exp_long  = 0;
        end
        vectors += 5;
        if (frame_toggle !== exp_toggle) begin
            miscompares++;
            $display("FAIL frameToggle got %b expected %b", frame_toggle, exp_toggle);
        end
        if (frame_count !== FCW'(exp_frames)) begin
            miscompares++;
            $display("FAIL frameCount got %0d expected %0d", frame_count, exp_frames);
        end
        if (short_count !== ECW'(exp_short)) begin
            miscompares++;
            $display("FAIL shortFrameCount got %0d expected %0d", short_count, exp_short);
        end
        if (long_count !== ECW'(exp_long)) begin
            miscompares++;
            $display("FAIL longFrameCount got %0d expected %0d", long_count, exp_long);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_frame got %b expected 0", busy);
        end
    endtask

    task automatic check_read(input int addr);
        read_address = AW'(addr);
        clock_and_score();
    endtask

    task automatic test_reset();
        read_address = '0;
        apply_reset();
        check_read(0);
        vectors += 4;
        if (frame_toggle !== 1'b0 || frame_count !== '0) begin
            miscompares++;
            $display("FAIL reset_frame toggle=%b count=%0d expected 0/0", frame_toggle, frame_count);
        end
        if (short_count !== '0 || long_count !== '0) begin
            miscompares++;
            $display("FAIL reset_errors short=%0d long=%0d expected 0/0", short_count, long_count);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b expected 0", busy);
        end
        if (read_data !== '0) begin
            miscompares++;
            $display("FAIL reset_readData got %h expected 0", read_data);
        end
    endtask

    task automatic test_good_frame();
        send_frame(RC, 0, 0, 1'b0);
        check_read(5);
        vectors += 2;
        if (read_data !== 32'h40A0_0000) begin
            miscompares++;
            $display("FAIL good_ch5 got %h expected 40a00000", read_data);
        end
        if (frame_toggle !== 1'b1 || frame_count !== FCW'(1)) begin
            miscompares++;
            $display("FAIL good_status toggle=%b count=%0d expected 1/1", frame_toggle, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        read_address = '0;
        send_frame(RC, 0, 0, 1'b0);
        send_frame(RC, 100, 0, 1'b0);
        check_read(0);
        vectors += 2;
        if (read_data !== 32'h42C8_0000) begin
            miscompares++;
            $display("FAIL b2b_ch0 got %h expected 42c80000", read_data);
        end
        if (frame_count !== FCW'(2)) begin
            miscompares++;
            $display("FAIL b2b_count got %0d expected 2", frame_count);
        end
    endtask

    task automatic test_short_frame();
        send_frame(11, 300, 0, 1'b0);
        for (int a = 0; a < RC; a += 7) check_read(a);
        send_frame(RC, 200, 0, 1'b0);
        check_read(3);
        check_read(RC - 1);
    endtask

    task automatic test_long_frame();
        send_frame(30, 400, 0, 1'b0);
        check_read(0);
        for (int i = 1; i < 300; i++) send_frame(30, 400, 0, 1'b0);
        vectors++;
        if (long_count !== 8'd255) begin
            miscompares++;
            $display("FAIL long_saturate got %0d expected 255", long_count);
        end
        send_frame(30, 400, 0, 1'b1);
        check_read(RC - 1);
    endtask

    task automatic test_reset_mid_frame();
        read_address = '0;
        for (int k = 0; k < 12; k++) begin
            tvalid = 1'b1;
            tlast  = 1'b0;
            tdata  = to_float(600 + k);
            clock_and_score();
        end
        reset       = 1'b1;
        tdata       = to_float(612);
        model_valid = 1'b0;
        exp_toggle  = 1'b0;
        exp_frames  = 0;
        exp_short   = 0;
        exp_long    = 0;
        clock_and_score();
        reset  = 1'b0;
        tvalid = 1'b0;
        send_frame(RC, 500, 0, 1'b0);
        check_read(0);
        vectors++;
        if (read_data !== to_float(500)) begin
            miscompares++;
            $display("FAIL reset_mid_ch0 got %h expected %h", read_data, to_float(500));
        end
    endtask

    task automatic test_addr_range();
        check_read(24);
        check_read(31);
        vectors++;
        if (read_data !== '0) begin
            miscompares++;
            $display("FAIL addr31 got %h expected 0", read_data);
        end
        check_read(RC - 1);
    endtask

    task automatic test_gaps();
        send_frame(RC, 700, 5, 1'b0);
        for (int a = 0; a < RC; a++) check_read(a);
        send_frame(RC, 800, 0, 1'b0);
        send_frame(RC, 700, 5, 1'b0);
        check_read(17);
        vectors++;
        if (read_data !== to_float(717)) begin
            miscompares++;
            $display("FAIL gaps_ch17 got %h expected %h", read_data, to_float(717));
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_addr_range();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps_setpoint_capture.md
# ps_setpoint_capture

Consumer end of the power-supply setpoint AXI stream: accepts the per-cycle burst of floating-point setpoints (one beat per channel, TLAST on the final channel, no back pressure) and validates framing. Each complete frame is committed atomically into a double-buffered setpoint bank. The bank is readable by the system bus, and the block keeps frame and error statistics. It sits between the setpoint calculator and the supply-link transmitters and bus readback, so software always sees a coherent set of setpoints from a single feedback cycle.

## Interface
- RESULT_COUNT, 24, beats (channels) per good frame
- FLOAT_WIDTH, 32, setpoint word width
- RESULT_COUNT_WIDTH, RESULT_COUNT==1 ? 1 : $clog2(RESULT_COUNT), channel index width
- FRAME_COUNT_WIDTH, 16, good-frame counter width
- ERROR_COUNT_WIDTH, 8, each error counter width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- SETPOINT_TVALID  in  1  beat valid; no TREADY, every valid beat is consumed
- SETPOINT_TLAST  in  1  last beat of frame
- SETPOINT_TDATA  in  FLOAT_WIDTH  IEEE single setpoint, amperes
- readAddress  in  RESULT_COUNT_WIDTH  channel to read from committed bank
- readData  out  FLOAT_WIDTH  committed setpoint for readAddress, registered
- frameToggle  out  1  flips on every committed frame
- frameCount  out  FRAME_COUNT_WIDTH  committed frames, wraps
- shortFrameCount  out  ERROR_COUNT_WIDTH  frames with TLAST early, saturating
- longFrameCount  out  ERROR_COUNT_WIDTH  frames with no TLAST on beat RESULT_COUNT-1, saturating
- clearErrors  in  1  single-cycle strobe; zeroes both error counters
- busy  out  1  high while a frame is partially received

## Operation
- Storage: two banks of RESULT_COUNT x FLOAT_WIDTH; one-bit readBank selects the committed bank, !readBank is the write bank.
- State machine (IDLE, RECEIVE, DISCARD), beat index idx:
  - IDLE: idx=0. On valid beat: write TDATA to writeBank[0].
    - TLAST with RESULT_COUNT==1: commit.
    - TLAST with RESULT_COUNT>1: short error.
    - Otherwise: idx<=1, go to RECEIVE.
  - RECEIVE: on valid beat, write TDATA to writeBank[idx].
    - TLAST && idx==RESULT_COUNT-1: commit, go to IDLE.
    - TLAST && idx<RESULT_COUNT-1: short error, go to IDLE.
    - !TLAST && idx==RESULT_COUNT-1: go to DISCARD.
    - Otherwise: idx++.
  - DISCARD: valid beats are ignored (no writes). On TLAST: long error, go to IDLE.
- Commit: readBank<=!readBank, frameToggle flips, frameCount+1 (wrap), bankValid<=1.
- Error frames never swap banks. The committed bank is never written, so a partial write-bank contents is harmless.
- Error counters saturate at all-ones. clearErrors in the same cycle as an increment: clear wins, so the result is 0.
- busy = (state != IDLE).
- TVALID low: state, idx and counters hold. TLAST/TDATA are ignored when TVALID is low.
- readData: 0 if !bankValid or readAddress>=RESULT_COUNT; otherwise bank[readBank][readAddress].
- Reset: state IDLE, idx 0, readBank 0, bankValid 0, frameToggle 0, all counters 0, readData 0, busy 0. Bank RAM is not cleared.
- Reset mid-frame: the partial frame is dropped with no error count. The next beat is treated as channel 0.

## Timing
- Beat at cycle N is written at edge N. Commit on the TLAST beat at N: frameToggle, frameCount and readBank updated at N+1.
- readData latency is 1 cycle from readAddress. readData uses the readBank value sampled at the same edge, so on commit edge N it still returns old-bank data, and new-frame data appears from N+2 for an address held from N+1.
- Back-to-back frames with zero idle cycles are required: a beat in the cycle after commit is channel 0 of the next frame.
- Error counters update at the edge following the offending TLAST beat.
- Throughput: one beat per clock sustained; no stall condition exists.

## Test plan
- Reset, then 24 valid beats TDATA=channel*1.0f with TLAST on beat 23 -> frameToggle=1, frameCount=1. readAddress=5 returns 0x40A00000 two cycles later. busy high for beats 1..23 only.
- Two back-to-back good frames (second frame = first +100.0f), reading channel 0 each cycle -> readData switches 0.0f→100.0f exactly at N+2 of the second TLAST, never mixed. frameCount=2.
- Frame with TLAST on beat 10 -> shortFrameCount=1, frameToggle unchanged, committed data unchanged. The following 24-beat frame commits normally.
- 30-beat frame with TLAST on beat 29 -> busy through beat 29, longFrameCount=1, no commit. 300 such frames -> counter holds 255. clearErrors coincident with the 301st error -> counter 0.
- Reset asserted at beat 12 of a frame, then a clean 24-beat frame -> no error counts, frameCount=1, channel 0 holds the first post-reset beat.
- readAddress=24 or 31 after a commit -> readData=0. Before any commit, readAddress=0 -> readData=0. TVALID gaps of 1–5 cycles inside a frame -> commit identical to the gapless case.
